// File: rtl/water_valve_controller.sv
// Hand-wash water valve controller: debounced request, minimum/maximum open
// time, and a lockout after a max-open timeout that needs a sustained release.
module water_valve_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned MIN_OPEN_CYCLES = 5000000,
    parameter int unsigned MAX_OPEN_CYCLES = 300000000,
    parameter int unsigned LOCKOUT_CYCLES  = 20000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waterOn,
    output logic        valveOpen,
    output logic        timeoutFlag,
    output logic [15:0] openCount
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        OPEN,
        CLOSING,
        LOCKOUT
    } stateType;

    localparam logic [31:0] DebounceLast = DEBOUNCE_CYCLES;
    localparam logic [31:0] MinOpenLast  = MIN_OPEN_CYCLES - 1;
    localparam logic [31:0] MaxOpenLast  = MAX_OPEN_CYCLES - 1;
    localparam logic [31:0] LockoutLast  = LOCKOUT_CYCLES - 1;

    stateType    stateQ, stateD;
    logic        s;
    logic [31:0] cnt, cntD;
    logic [31:0] ot, otD;
    logic        bumpCount;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        stateD    = stateQ;
        cntD      = cnt;
        otD       = ot;
        bumpCount = 1'b0;

        case (stateQ)
            IDLE: begin
                if (s) begin
                    stateD = ARM;
                    cntD   = 32'd1;
                end
            end

            ARM: begin
                if (!s) begin
                    stateD = IDLE;
                end else if (cnt == DebounceLast) begin
                    stateD    = OPEN;
                    otD       = '0;
                    bumpCount = 1'b1;
                end else begin
                    cntD = cnt + 32'd1;
                end
            end

            OPEN, CLOSING: begin
                otD = ot + 32'd1;
                // The max-open timeout outranks every other exit from either open state.
                if (ot == MaxOpenLast) begin
                    stateD = LOCKOUT;
                    cntD   = '0;
                    otD    = '0;
                end else if (stateQ == OPEN) begin
                    if (!s && ot >= MinOpenLast) begin
                        stateD = CLOSING;
                        cntD   = 32'd1;
                    end
                end else if (s) begin
                    stateD = OPEN;
                end else if (cnt == DebounceLast) begin
                    stateD = IDLE;
                end else begin
                    cntD = cnt + 32'd1;
                end
            end

            LOCKOUT: begin
                if (s) begin
                    cntD = '0;
                end else if (cnt == LockoutLast) begin
                    stateD = IDLE;
                end else begin
                    cntD = cnt + 32'd1;
                end
            end

            default: begin
                stateD = IDLE;
                cntD   = '0;
                otD    = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            stateQ      <= IDLE;
            s           <= 1'b0;
            cnt         <= '0;
            ot          <= '0;
            valveOpen   <= 1'b0;
            timeoutFlag <= 1'b0;
            openCount   <= '0;
        end else begin
            stateQ      <= stateD;
            s           <= waterOn;
            cnt         <= cntD;
            ot          <= otD;
            valveOpen   <= (stateD == OPEN) || (stateD == CLOSING);
            timeoutFlag <= (stateD == LOCKOUT);
            if (bumpCount && openCount != 16'hFFFF) begin
                openCount <= openCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_water_valve_controller.sv
// Self-checking bench: table-driven per-cycle vectors through a scoreboard queue,
// plus a second small-parameter instance that drives openCount into saturation.
`timescale 1ns/1ps
module tb_water_valve_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        waterOn;
    logic        valveOpen;
    logic        timeoutFlag;
    logic [15:0] openCount;

    logic        clkS = 1'b0;
    logic        resetS;
    logic        waterOnS;
    logic        valveOpenS;
    logic        timeoutFlagS;
    logic [15:0] openCountS;

    always #5 clk = ~clk;
    always #1 clkS = ~clkS;

    water_valve_controller #(
        .DEBOUNCE_CYCLES(4),
        .MIN_OPEN_CYCLES(10),
        .MAX_OPEN_CYCLES(50),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .waterOn    (waterOn),
        .valveOpen  (valveOpen),
        .timeoutFlag(timeoutFlag),
        .openCount  (openCount)
    );

    water_valve_controller #(
        .DEBOUNCE_CYCLES(1),
        .MIN_OPEN_CYCLES(1),
        .MAX_OPEN_CYCLES(4),
        .LOCKOUT_CYCLES (1)
    ) dutSat (
        .clk        (clkS),
        .reset      (resetS),
        .waterOn    (waterOnS),
        .valveOpen  (valveOpenS),
        .timeoutFlag(timeoutFlagS),
        .openCount  (openCountS)
    );

    typedef struct {
        logic        rst;
        logic        w;
        int          n;
        logic        ev;
        logic        ef;
        logic [15:0] ec;
    } segType;

    typedef struct {
        logic        ev;
        logic        ef;
        logic [15:0] ec;
    } expType;

    segType segs[$];
    expType sb[$];
    int     compared   = 0;
    int     mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic rst, input logic w, input int n,
                       input logic ev, input logic ef, input logic [15:0] ec);
        segType sg;
        sg.rst = rst; sg.w = w; sg.n = n; sg.ev = ev; sg.ef = ef; sg.ec = ec;
        segs.push_back(sg);
    endtask

    initial begin
        expType e;
        int     expSat;

        reset    = 1'b0;
        waterOn  = 1'b0;
        resetS   = 1'b0;
        waterOnS = 1'b0;

        // {reset, waterOn, cycles, valveOpen, timeoutFlag, openCount} after each edge
        add(0, 0,  2, 0, 0, 0);    // reset state
        add(1, 1,  5, 0, 0, 0);    // debounce in progress
        add(1, 1, 50, 1, 0, 1);    // open 50 cycles, request held
        add(1, 1,  2, 0, 1, 1);    // forced close into lockout
        add(1, 0,  5, 0, 1, 1);
        add(1, 1,  1, 0, 1, 1);    // blip restarts the lockout count
        add(1, 0,  8, 0, 1, 1);
        add(1, 0,  1, 0, 0, 1);    // lockout released
        add(1, 0,  2, 0, 0, 1);
        add(1, 1,  5, 0, 0, 1);    // fresh debounce required
        add(1, 1,  1, 1, 0, 2);
        add(1, 0, 13, 1, 0, 2);    // minimum-open hold then 4-cycle closing
        add(1, 0,  1, 0, 0, 2);
        add(1, 0,  2, 0, 0, 2);
        add(1, 1,  5, 0, 0, 2);
        add(1, 1,  1, 1, 0, 3);
        add(1, 0,  9, 1, 0, 3);
        add(1, 1,  2, 1, 0, 3);    // pulse during closing reopens
        add(1, 0,  5, 1, 0, 3);    // ot kept running, so closing starts at once
        add(1, 0,  1, 0, 0, 3);
        add(1, 0,  2, 0, 0, 3);
        add(1, 1,  3, 0, 0, 3);    // too-short request
        add(1, 0,  4, 0, 0, 3);
        add(1, 1,  4, 0, 0, 3);    // one cycle short of debounce
        add(1, 0,  4, 0, 0, 3);
        add(1, 1,  5, 0, 0, 3);
        add(1, 1,  1, 1, 0, 4);
        add(1, 1,  3, 1, 0, 4);
        add(0, 1,  1, 0, 0, 0);    // reset mid-open closes immediately
        add(1, 1,  5, 0, 0, 0);
        add(1, 1,  1, 1, 0, 1);
        add(1, 1, 49, 1, 0, 1);
        add(1, 1,  1, 0, 1, 1);
        add(0, 0,  1, 0, 0, 0);    // reset clears lockout
        add(1, 0,  3, 0, 0, 0);

        foreach (segs[i]) begin
            for (int k = 0; k < segs[i].n; k++) begin
                reset   = segs[i].rst;
                waterOn = segs[i].w;
                sb.push_back('{ev: segs[i].ev, ef: segs[i].ef, ec: segs[i].ec});
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check($sformatf("seg%0d.%0d valveOpen", i, k), {31'd0, valveOpen}, {31'd0, e.ev});
                check($sformatf("seg%0d.%0d timeoutFlag", i, k), {31'd0, timeoutFlag}, {31'd0, e.ef});
                check($sformatf("seg%0d.%0d openCount", i, k), {16'd0, openCount}, {16'd0, e.ec});
            end
        end

        // Saturation: each event is waterOn 1,1,0,0 -> IDLE, ARM, OPEN, CLOSING, back to IDLE.
        @(negedge clkS);
        @(negedge clkS);
        resetS = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clkS) waterOnS = 1'b1;
            @(negedge clkS) waterOnS = 1'b1;
            @(negedge clkS) waterOnS = 1'b0;
            @(negedge clkS);
            expSat = (i + 1 > 65535) ? 65535 : i + 1;
            check($sformatf("sat ev%0d valveOpen", i), {31'd0, valveOpenS}, 32'd1);
            check($sformatf("sat ev%0d openCount", i), {16'd0, openCountS}, expSat);
            waterOnS = 1'b0;
        end
        @(negedge clkS);
        @(negedge clkS);
        check("sat final valveOpen", {31'd0, valveOpenS}, 32'd0);
        check("sat final timeoutFlag", {31'd0, timeoutFlagS}, 32'd0);
        check("sat final openCount", {16'd0, openCountS}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
